// File: rtl/bus_wr_pkg.sv
// Shared types, default constants and width helpers for the bus write arbiter.
// Contents:
//   state_e   - write FSM states (IDLE, STROBE, GAP)
//   BUS_*     - default address/data widths and strobe/gap lengths
//   idx_width - bit width of a requester index
//   cnt_width - bit width of the strobe/gap down-counter
package bus_wr_pkg;

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_e;

    localparam int unsigned BUS_AW      = 32;
    localparam int unsigned BUS_DW      = 32;
    localparam int unsigned BUS_WR_CYC  = 3;
    localparam int unsigned BUS_GAP_CYC = 1;

    // At least one bit so a single-entry index still has a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized from the largest reload value; never smaller than one bit.
    function automatic int unsigned cnt_width(input int unsigned wr_cyc,
                                              input int unsigned gap_cyc);
        int unsigned m;
        m = 2;
        if (wr_cyc > m) m = wr_cyc;
        if (gap_cyc > m) m = gap_cyc;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/bus_wr_arbiter_if.sv
// Requester handshake plus active-low write bus bundle for bus_wr_arbiter.
// Signals:
//   req_valid/req_ready   per-requester handshake (ready is a one-hot grant)
//   req_addr/req_data     packed per-requester address/data, slice i at [i*W +: W]
//   cs/wr                 active-low chip select and write strobe
//   addr/data             bus address and write data
//   busy                  arbiter not idle
//   grant_id              index of the last granted requester
// Modports: master = arbiter side, slave = requesters/bus side.
interface bus_wr_arbiter_if import bus_wr_pkg::*; #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = BUS_AW,
    parameter int unsigned DW    = BUS_DW
);
    localparam int unsigned IW = idx_width(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic                cs;
    logic                wr;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       data;
    logic                busy;
    logic [IW-1:0]       grant_id;

    modport master (
        input  req_valid, req_addr, req_data,
        output req_ready, cs, wr, addr, data, busy, grant_id
    );

    modport slave (
        output req_valid, req_addr, req_data,
        input  req_ready, cs, wr, addr, data, busy, grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational requester picker.
// Default: round-robin, first request at or after ptr, wrapping.
// With BUS_WR_FIXED_PRIO_EN defined: lowest index wins, ptr is ignored and next_ptr is 0.
// Ports:
//   req      in   request vector
//   ptr      in   round-robin start index
//   en       in   allow a grant this cycle
//   grant    out  one-hot grant (zero when en is low or nothing requests)
//   idx      out  binary index of the winner (valid when any req is high)
//   next_ptr out  pointer value to load when this grant is taken
module rr_arbiter import bus_wr_pkg::*; #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic [IW-1:0]    next_ptr
);

    logic found;

`ifdef BUS_WR_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        next_ptr = '0;
    end
`else
    always_comb begin
        int unsigned j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            j = (int'(ptr) + off) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        // The winner drops to lowest priority for the next round.
        next_ptr = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
`endif

    always_comb begin
        grant      = '0;
        grant[idx] = en & found;
    end

endmodule

// File: rtl/bus_wr_arbiter.sv
// Shares one active-low cs/wr write bus between N_REQ valid/ready requesters.
// A winner is accepted in IDLE, the bus is driven for WR_CYC cycles with cs/wr low,
// then cs/wr stay high for GAP_CYC cycles before the next grant.
// Optional build macro: BUS_WR_FIXED_PRIO_EN (fixed priority instead of round-robin,
// handled inside rr_arbiter).
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset; abandons any write in flight
//   bus    bus_wr_arbiter_if.master: requester handshake, cs/wr/addr/data, busy, grant_id
module bus_wr_arbiter import bus_wr_pkg::*; #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned AW      = BUS_AW,
    parameter int unsigned DW      = BUS_DW,
    parameter int unsigned WR_CYC  = BUS_WR_CYC,
    parameter int unsigned GAP_CYC = BUS_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_wr_arbiter_if.master  bus
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned CW = cnt_width(WR_CYC, GAP_CYC);
    localparam logic [CW-1:0] WrLoad  = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] GapLoad = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          cs_q, cs_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] gid_q, gid_d;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    ptr_nxt;
    logic             arb_en;

    assign arb_en = (state_q == IDLE);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .en       (arb_en),
        .grant    (grant),
        .idx      (gidx),
        .next_ptr (ptr_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gid_d   = gid_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    addr_d  = bus.req_addr[gidx*AW +: AW];
                    data_d  = bus.req_data[gidx*DW +: DW];
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    gid_d   = gidx;
                    ptr_d   = ptr_nxt;
                    cnt_d   = WrLoad;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cs_d   = 1'b1;
                    wr_d   = 1'b1;
                    addr_d = '0;
                    data_d = '0;
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = GapLoad;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.cs        = cs_q;
    assign bus.wr        = wr_q;
    assign bus.addr      = addr_q;
    assign bus.data      = data_q;
    assign bus.grant_id  = gid_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_wr_arbiter.sv
// Directed bench for bus_wr_arbiter at defaults (4 requesters, WR_CYC=3, GAP_CYC=1).
// Honours BUS_WR_FIXED_PRIO_EN for the expected grant orders.
module tb_bus_wr_arbiter;
    import bus_wr_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_wr_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

    bus_wr_arbiter #(
        .N_REQ   (N),
        .AW      (AW),
        .DW      (DW),
        .WR_CYC  (3),
        .GAP_CYC (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: logs grants, cs-low start cycles and cs-low run lengths.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   grants[$];
    int   cs_start[$];
    int   cs_len[$];
    int   onehot_err = 0;
    logic prev_cs = 1'b1;
    int   run = 0;

    always @(negedge clk) begin
        int k;
        if (!rst_n) begin
            prev_cs = 1'b1;
            run     = 0;
        end else begin
            if (bus.req_ready != '0) begin
                if (!$onehot(bus.req_ready)) onehot_err++;
                k = 0;
                for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) k = i;
                grants.push_back(k);
            end
            if (!bus.cs) begin
                if (prev_cs) cs_start.push_back(cyc);
                run++;
            end else if (!prev_cs) begin
                cs_len.push_back(run);
                run = 0;
            end
            prev_cs = bus.cs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 20) begin
            tick();
            k++;
        end
        check("idle_timeout", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic check_seq(input string tag, input int base, input int exp[$]);
        check({tag, "_count"}, 64'(grants.size() - base), 64'(exp.size()));
        foreach (exp[i]) begin
            if (base + i < grants.size())
                check($sformatf("%s[%0d]", tag, i), 64'(grants[base + i]), 64'(exp[i]));
        end
    endtask

    initial begin
        int gb, sb, lb, oh0, pairs;
        int e3[$];
        int e4[$];
        int e5[$];

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb, sb, lb, oh0, pairs;
        int e3[$];
        int e4[$];
        int e5[$];

`ifdef BUS_WR_FIXED_PRIO_EN
        e3 = {0, 0, 0, 0, 0};
        e4 = {0, 0, 0, 0};
`else
        e3 = {0, 1, 2, 3, 0};
        e4 = {2, 0, 2, 0};
`endif
        e5 = {1};

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs",    {63'd0, bus.cs}, 64'd1);
        check("rst_wr",    {63'd0, bus.wr}, 64'd1);
        check("rst_addr",  64'(bus.addr), 64'd0);
        check("rst_data",  64'(bus.data), 64'd0);
        check("rst_busy",  {63'd0, bus.busy}, 64'd0);
        check("rst_gid",   64'(bus.grant_id), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_hold_busy", {63'd0, bus.busy}, 64'd0);
        check("idle_hold_cs",   {63'd0, bus.cs}, 64'd1);

        // Single write from requester 1
        lb = cs_len.size();
        set_req(1, 32'h1100008a, 32'h11113000);
        bus.req_valid = 4'b0010;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 4'b0000;
        check("single_ready_off", 64'(bus.req_ready), 64'h0);
        check("single_cs",   {63'd0, bus.cs}, 64'd0);
        check("single_wr",   {63'd0, bus.wr}, 64'd0);
        check("single_addr", 64'(bus.addr), 64'h1100008a);
        check("single_data", 64'(bus.data), 64'h11113000);
        check("single_gid",  64'(bus.grant_id), 64'd1);
        check("single_busy", {63'd0, bus.busy}, 64'd1);
        tick();
        tick();
        check("single_cs3",   {63'd0, bus.cs}, 64'd0);
        check("single_addr3", 64'(bus.addr), 64'h1100008a);
        tick();
        check("gap_cs",   {63'd0, bus.cs}, 64'd1);
        check("gap_addr", 64'(bus.addr), 64'd0);
        check("gap_busy", {63'd0, bus.busy}, 64'd1);
        tick();
        check("post_busy", {63'd0, bus.busy}, 64'd0);
        check("single_len", 64'(cs_len.size() - lb), 64'd1);
        if (cs_len.size() > lb) check("single_len_val", 64'(cs_len[lb]), 64'd3);

        // Reset during the second STROBE cycle of a write from requester 2
        set_req(2, 32'h22000040, 32'ha5a50002);
        bus.req_valid = 4'b0100;
        #1;
        check("mid_ready", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = 4'b0000;
        check("mid_cs_pre", {63'd0, bus.cs}, 64'd0);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs",   {63'd0, bus.cs}, 64'd1);
        check("mid_rst_wr",   {63'd0, bus.wr}, 64'd1);
        check("mid_rst_addr", 64'(bus.addr), 64'd0);
        check("mid_rst_data", 64'(bus.data), 64'd0);
        check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // All four requesters valid continuously; pointer restarts at 0
        for (int i = 0; i < N; i++) set_req(i, 32'h1000 + i, 32'hd000 + i);
        gb  = grants.size();
        sb  = cs_start.size();
        lb  = cs_len.size();
        oh0 = onehot_err;
        bus.req_valid = 4'b1111;
        #1;
        check("all_first_ready", 64'(bus.req_ready), 64'h1);
        repeat (22) tick();
        bus.req_valid = 4'b0000;
        wait_idle();
        check_seq("all_grant", gb, e3);
        check("all_starts", 64'(cs_start.size() - sb), 64'd5);
        for (int i = 1; i < 5; i++) begin
            if (sb + i < cs_start.size())
                check($sformatf("all_spacing[%0d]", i),
                      64'(cs_start[sb + i] - cs_start[sb + i - 1]), 64'd5);
        end
        for (int i = 0; i < 5; i++) begin
            if (lb + i < cs_len.size())
                check($sformatf("all_len[%0d]", i), 64'(cs_len[lb + i]), 64'd3);
        end
        check("all_onehot", 64'(onehot_err - oh0), 64'd0);

        // Requesters 0 and 2 always valid
        gb = grants.size();
        bus.req_valid = 4'b0101;
        repeat (18) tick();
        bus.req_valid = 4'b0000;
        wait_idle();
        check_seq("fair_grant", gb, e4);
`ifndef BUS_WR_FIXED_PRIO_EN
        pairs = 0;
        for (int i = gb + 1; i < grants.size(); i++)
            if (grants[i] == 0 && grants[i - 1] == 0) pairs++;
        check("fair_no_repeat0", 64'(pairs), 64'd0);
`endif

        // Requester 3 withdraws while requester 1 is being served
        gb = grants.size();
        sb = cs_start.size();
        bus.req_valid = 4'b1010;
        #1;
        check("wd_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0000;
        repeat (8) tick();
        check_seq("wd_grant", gb, e5);
        check("wd_cs_pulses", 64'(cs_start.size() - sb), 64'd1);
        check("wd_cs_idle", {63'd0, bus.cs}, 64'd1);
        check("wd_busy", {63'd0, bus.busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
